// File: rtl/pipe_pkg.sv
// Shared constants for the pipelined MIPS32 ID stage: opcodes, funcs, ALU and
// PC-select encodings, MDU op encoding and the forwarding-code helper.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JR     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    // Odd codes select a stage's ALU result, even codes its load data.
    function automatic int unsigned fwd_code(input int unsigned k, input logic m2reg);
        return m2reg ? (2 * k + 2) : (2 * k + 1);
    endfunction

endpackage

// File: rtl/pipeidcu_fwdn_if.sv
// ID-stage control bus: decode/forwarding inputs from the pipeline and the
// control outputs back to the datapath. master = pipeline side, slave = control unit.
interface pipeidcu_fwdn_if #(
    parameter int NFWD = 3,
    parameter int FW   = $clog2(2 * NFWD + 1)
);
    logic [5:0]        op;
    logic [5:0]        func;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [5*NFWD-1:0] st_rn;
    logic [NFWD-1:0]   st_wreg;
    logic [NFWD-1:0]   st_m2reg;
    logic              rsrtequ;

    logic [3:0]        aluc;
    logic [1:0]        pcsrc;
    logic [FW-1:0]     fwda;
    logic [FW-1:0]     fwdb;
    logic              wreg, m2reg, wmem, aluimm, shift, jal, regrt, sext;
    logic              mdu_start;
    logic [1:0]        mdu_op;
    logic              mfhilo, hisel;
    logic              mdu_busy;
    logic              nostall;
    logic [15:0]       stall_cnt;

    modport master (
        output op, func, rs, rt, st_rn, st_wreg, st_m2reg, rsrtequ,
        input  aluc, pcsrc, fwda, fwdb, wreg, m2reg, wmem, aluimm, shift, jal,
               regrt, sext, mdu_start, mdu_op, mfhilo, hisel, mdu_busy,
               nostall, stall_cnt
    );

    modport slave (
        input  op, func, rs, rt, st_rn, st_wreg, st_m2reg, rsrtequ,
        output aluc, pcsrc, fwda, fwdb, wreg, m2reg, wmem, aluimm, shift, jal,
               regrt, sext, mdu_start, mdu_op, mfhilo, hisel, mdu_busy,
               nostall, stall_cnt
    );
endinterface

// File: rtl/mdu_scoreboard.sv
// MDU busy counter and saturating stall-cycle counter; the only sequential
// state in the decode path.
module mdu_scoreboard #(
    parameter int MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mdu_start,
    input  logic        nostall,
    output logic        mdu_busy,
    output logic [15:0] stall_cnt
);
    logic [3:0] mcnt;

    // Issue only happens with mcnt==0, so load and decrement never compete.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mcnt <= 4'd0;
        end else if (mdu_start) begin
            mcnt <= 4'(MDU_LAT);
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= 16'd0;
        end else if (!nostall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign mdu_busy = (mcnt != 4'd0);

endmodule

// File: rtl/pipeidcu_fwdn.sv
// ID-stage control unit: instruction decode, NFWD-stage operand forwarding,
// load-use and MDU interlocks, and the global nostall.
module pipeidcu_fwdn
    import pipe_pkg::*;
#(
    parameter int NFWD       = 3,
    parameter int LOAD_STAGE = 1,
    parameter int MDU_LAT    = 4,
    parameter int FW         = $clog2(2 * NFWD + 1)
) (
    input logic            clk,
    input logic            clrn,
    pipeidcu_fwdn_if.slave bus
);
    logic [3:0] aluc_d;
    logic [1:0] pcsrc_d;
    logic       wreg_d, wmem_d, m2reg_d, aluimm_d, shift_d, jal_d, regrt_d, sext_d;
    logic       use_rs, use_rt, is_mdu, is_mfhi, is_mflo;

    always_comb begin
        aluc_d   = ALU_ADD;
        pcsrc_d  = PC_SEQ;
        wreg_d   = 1'b0;
        wmem_d   = 1'b0;
        m2reg_d  = 1'b0;
        aluimm_d = 1'b0;
        shift_d  = 1'b0;
        jal_d    = 1'b0;
        regrt_d  = 1'b0;
        sext_d   = 1'b0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        is_mdu   = 1'b0;
        is_mfhi  = 1'b0;
        is_mflo  = 1'b0;
        case (bus.op)
            OP_RTYPE: begin
                case (bus.func)
                    FN_ADD: begin wreg_d = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                    FN_SUB: begin wreg_d = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc_d = ALU_SUB; end
                    FN_AND: begin wreg_d = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc_d = ALU_AND; end
                    FN_OR:  begin wreg_d = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc_d = ALU_OR;  end
                    FN_XOR: begin wreg_d = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc_d = ALU_XOR; end
                    FN_SLL: begin wreg_d = 1'b1; use_rt = 1'b1; shift_d = 1'b1; aluc_d = ALU_SLL; end
                    FN_SRL: begin wreg_d = 1'b1; use_rt = 1'b1; shift_d = 1'b1; aluc_d = ALU_SRL; end
                    FN_SRA: begin wreg_d = 1'b1; use_rt = 1'b1; shift_d = 1'b1; aluc_d = ALU_SRA; end
                    FN_JR:  begin use_rs = 1'b1; pcsrc_d = PC_JR; end
                    FN_MFHI: begin wreg_d = 1'b1; is_mfhi = 1'b1; end
                    FN_MFLO: begin wreg_d = 1'b1; is_mflo = 1'b1; end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        use_rs = 1'b1; use_rt = 1'b1; is_mdu = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin wreg_d = 1'b1; use_rs = 1'b1; aluimm_d = 1'b1; sext_d = 1'b1; regrt_d = 1'b1; end
            OP_ANDI: begin wreg_d = 1'b1; use_rs = 1'b1; aluimm_d = 1'b1; regrt_d = 1'b1; aluc_d = ALU_AND; end
            OP_ORI:  begin wreg_d = 1'b1; use_rs = 1'b1; aluimm_d = 1'b1; regrt_d = 1'b1; aluc_d = ALU_OR;  end
            OP_XORI: begin wreg_d = 1'b1; use_rs = 1'b1; aluimm_d = 1'b1; regrt_d = 1'b1; aluc_d = ALU_XOR; end
            OP_LW: begin
                wreg_d = 1'b1; m2reg_d = 1'b1; use_rs = 1'b1;
                aluimm_d = 1'b1; sext_d = 1'b1; regrt_d = 1'b1;
            end
            OP_SW: begin wmem_d = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluimm_d = 1'b1; sext_d = 1'b1; end
            OP_BEQ: begin
                use_rs = 1'b1; use_rt = 1'b1; sext_d = 1'b1;
                pcsrc_d = bus.rsrtequ ? PC_BRANCH : PC_SEQ;
            end
            OP_BNE: begin
                use_rs = 1'b1; use_rt = 1'b1; sext_d = 1'b1;
                pcsrc_d = bus.rsrtequ ? PC_SEQ : PC_BRANCH;
            end
            OP_LUI: begin wreg_d = 1'b1; aluimm_d = 1'b1; regrt_d = 1'b1; aluc_d = ALU_LUI; end
            OP_J:   begin pcsrc_d = PC_JUMP; end
            OP_JAL: begin wreg_d = 1'b1; jal_d = 1'b1; pcsrc_d = PC_JUMP; end
            default: ;
        endcase
    end

    logic [NFWD-1:0] hit_a, hit_b;

    for (genvar k = 0; k < NFWD; k++) begin : g_stage
        logic [4:0] rn;
        assign rn       = bus.st_rn[5*k +: 5];
        assign hit_a[k] = bus.st_wreg[k] && (rn != 5'd0) && (rn == bus.rs);
        assign hit_b[k] = bus.st_wreg[k] && (rn != 5'd0) && (rn == bus.rt);
    end

    logic [FW-1:0] fwda_d, fwdb_d;
    logic          lu_a, lu_b;

    // Scan oldest to youngest so the lowest matching stage overwrites the rest.
    always_comb begin
        fwda_d = '0;
        fwdb_d = '0;
        lu_a   = 1'b0;
        lu_b   = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (hit_a[k]) begin
                fwda_d = FW'(fwd_code(unsigned'(k), bus.st_m2reg[k]));
                lu_a   = bus.st_m2reg[k] && (k < LOAD_STAGE);
            end
            if (hit_b[k]) begin
                fwdb_d = FW'(fwd_code(unsigned'(k), bus.st_m2reg[k]));
                lu_b   = bus.st_m2reg[k] && (k < LOAD_STAGE);
            end
        end
    end

    logic    mdu_busy, nostall, mdu_start;
    mdu_op_e mop;

    assign nostall   = !((use_rs && lu_a) || (use_rt && lu_b) ||
                         ((is_mdu || is_mfhi || is_mflo) && mdu_busy));
    assign mdu_start = is_mdu && nostall;
    assign mop       = mdu_op_e'(bus.func[1:0]);

    mdu_scoreboard #(.MDU_LAT(MDU_LAT)) u_mdu_scoreboard (
        .clk       (clk),
        .clrn      (clrn),
        .mdu_start (mdu_start),
        .nostall   (nostall),
        .mdu_busy  (mdu_busy),
        .stall_cnt (bus.stall_cnt)
    );

    assign bus.aluc      = aluc_d;
    assign bus.pcsrc     = pcsrc_d;
    assign bus.fwda      = fwda_d;
    assign bus.fwdb      = fwdb_d;
    assign bus.wreg      = wreg_d && nostall;
    assign bus.wmem      = wmem_d && nostall;
    assign bus.m2reg     = m2reg_d;
    assign bus.aluimm    = aluimm_d;
    assign bus.shift     = shift_d;
    assign bus.jal       = jal_d;
    assign bus.regrt     = regrt_d;
    assign bus.sext      = sext_d;
    assign bus.mdu_start = mdu_start;
    assign bus.mdu_op    = mop;
    assign bus.mfhilo    = is_mfhi || is_mflo;
    assign bus.hisel     = is_mfhi;
    assign bus.mdu_busy  = mdu_busy;
    assign bus.nostall   = nostall;

endmodule

// File: doc/pipeidcu_fwdn.md
# pipeidcu_fwdn

ID-stage control unit for the pipelined MIPS32 core, generalised over the number of forwarding stages, with load-use interlock and a multi-cycle multiply/divide (MDU) interlock. It decodes the ID instruction and drives datapath controls, per-operand forwarding selects, branch/jump PC select and the global `nostall`. It adds the only sequential state in the decode path: the MDU busy counter and a stall counter.

## Interface
Parameters:
- `NFWD`, 3, forwarding stages after ID; stage 0 = EXE, 1 = MEM, 2 = WB.
- `LOAD_STAGE`, 1, first stage index whose load data can be forwarded.
- `MDU_LAT`, 4, MDU busy cycles per mult/div, 1..15.
- `FW`, `$clog2(2*NFWD+1)`, forwarding-select width (derived).

Ports:
- Clock: one clock, `clk`, rising edge.
- Reset: asynchronous, active-low, `clrn`.
- `op`, `func`: in, 6 each; ID instruction fields.
- `rs`, `rt`: in, 5 each; ID source registers.
- `st_rn`: in, 5*NFWD; destination register of stage k at bits [5k+4:5k].
- `st_wreg`: in, NFWD; stage k writes the register file.
- `st_m2reg`: in, NFWD; stage k holds a load.
- `rsrtequ`: in, 1; rs value equals rt value after forwarding.
- `aluc`, `pcsrc`: out, 4/2; ALU control, PC select (00 pc+4, 01 branch, 10 jr, 11 jump).
- `fwda`, `fwdb`: out, FW each; 0 register file, 2k+1 stage-k ALU result, 2k+2 stage-k load data.
- `wreg`, `m2reg`, `wmem`, `aluimm`, `shift`, `jal`, `regrt`, `sext`: out, 1 each; datapath controls.
- `mdu_start`: out, 1; issue mult/div this cycle.
- `mdu_op`: out, 2; 00 mult, 01 multu, 10 div, 11 divu.
- `mfhilo`, `hisel`: out, 1 each; mfhi/mflo in ID; 1 selects HI.
- `mdu_busy`: out, 1; MDU counter non-zero.
- `nostall`: out, 1; low freezes PC and IF/ID.
- `stall_cnt`: out, 16; saturating count of stall cycles.

## Operation
- Decode covers add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. It adds mult, multu, div, divu (func 011000..011011) and mfhi, mflo (func 010000/010010).
- ALU codes, immediate, sign-extend and pcsrc encodings are unchanged for the base set.
- mfhi/mflo: wreg=1, regrt=0, mfhilo=1.
- mult/div: use rs and rt, wreg=0.
- rs users: base rs users plus mult/div. rt users: base rt users plus mult/div.
- Stage match for operand x: `st_wreg[k]` & `st_rn[k]!=0` & `st_rn[k]==x`.
- fwd select: the lowest matching k wins (youngest). The code is 2k+2 if `st_m2reg[k]`, else 2k+1. With no match the code is 0.
- Load-use stall: the winning match for a used operand has `st_m2reg[k]` and `k<LOAD_STAGE`.
- MDU stall: (mult/div or mfhi/mflo in ID) & `mdu_busy`.
- `nostall` is low when either stall condition holds.
- wreg, wmem and mdu_start are gated by nostall. fwda/fwdb are checked only when nostall=1.
- MDU counter `mcnt` (4 bits):
  - If `mdu_start`, load MDU_LAT.
  - Else if non-zero, decrement.
  - `mdu_busy = (mcnt!=0)`.
- `stall_cnt` increments on every edge where nostall=0 and holds at 16'hFFFF.

## Timing
- All decode, forwarding and stall outputs are combinational from the inputs and `mcnt`.
- Reset (async, clrn=0): mcnt=0, mdu_busy=0, stall_cnt=0. Combinational outputs follow the inputs during reset.
- Reset during an MDU operation clears busy immediately. The next mfhi does not stall.
- Mult accepted in cycle t: mdu_busy is high in cycles t+1..t+MDU_LAT. A dependent mfhi proceeds at t+MDU_LAT+1 at the earliest.
- A mult/div arriving while `mcnt==1` stalls one cycle, then issues and reloads the counter.
- Issue and decrement never coincide, because issue requires mcnt=0.
- Load-use stall with LOAD_STAGE=1: exactly one stall cycle. The next cycle the load sits in stage 1 and forwards code 4.

## Structure
- Shared package `pipe_pkg`:
  - opcode and func constants
  - aluc and pcsrc encodings
  - mdu_op encoding
  - function `fwd_code(k, m2reg)`
- Sub-module `mdu_scoreboard`:
  - contents: mcnt, mdu_busy, stall_cnt
  - inputs: clk, clrn, mdu_start, nostall
  - parameter: MDU_LAT
- Top-level: decode and forwarding priority, built as a generate loop over NFWD.

## Test plan
- Default parameters. add $3 with stage 0 = ALU write $3 and stage 1 = ALU write $3 → fwda=1 (youngest wins). With st_rn[0]=0 → fwda=3.
- lw $5 in stage 0, then add $6,$5,$5 → nostall=0, wreg=0, stall_cnt +1. Next cycle (lw in stage 1) → fwda=fwdb=4, nostall=1.
- Write to $0 in every stage, sub $1,$0,$0 → fwda=fwdb=0, nostall=1.
- mult at t, mfhi at t+1 → nostall=0 for cycles t+1..t+4. mfhi issues at t+5 with mfhilo=1, hisel=1.
- mult at t, mult at t+1 → second mult stalls until t+5, then mdu_start=1, mdu_busy high t+6..t+9.
- clrn pulsed low at t+2 mid-mult → mdu_busy=0 and stall_cnt=0 asynchronously. mflo then proceeds with no stall.
- NFWD=4, LOAD_STAGE=2: load in stage 1 matching rt → stall. Same load in stage 2 → fwdb=6.
